// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin mux arbiter
// and the arbiters built on the same picker.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        logic [N_REQ-1:0] oh;
        oh    = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4.sv
// Shared 4:1 mux datapath, W bits wide, two-bit select.
module mux4 #(
    parameter int W = 2
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   s,
    output logic [W-1:0] y
);

    // NOTE: combinational blocks use blocking '=' so later statements see the value just computed.
    always_comb begin
        case (s)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo 4.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    // Rotating the doubled vector puts the requester at ptr into bit 0.
    assign req_dbl = {req, req};
    assign rot     = req_dbl[ptr +: N_REQ];

    always_comb begin
        off = '0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign idx = ptr + off;
    assign any = |req;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the shared 4:1 mux select and a valid/ready
// output channel; a grant may carry up to BURST beats before rotating.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W = 2,
    parameter int BURST  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        ack,
    output logic [SEL_W-1:0]        sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [SEL_W-1:0]        out_id
);

    localparam int               CNT_W    = $clog2(BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  mux_y;
    logic               beat;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    mux4 #(.W(DATA_W)) u_mux (
        .d0 (data_in[0*DATA_W +: DATA_W]),
        .d1 (data_in[1*DATA_W +: DATA_W]),
        .d2 (data_in[2*DATA_W +: DATA_W]),
        .d3 (data_in[3*DATA_W +: DATA_W]),
        .s  (sel_q),
        .y  (mux_y)
    );

    // Outputs derive only from registered state plus the live mux path, so
    // an async reset clears them without waiting for a clock.
    assign out_valid = (state_q == ST_GRANT);
    assign beat      = out_valid & out_ready;
    assign ack       = beat ? sel_onehot(sel_q) : '0;
    assign out_data  = out_valid ? mux_y : '0;
    assign sel       = sel_q;
    assign out_id    = sel_q;

    // NOTE: every _d signal takes its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Another beat is kept only if the requester still asks during
                // the ack cycle and the burst budget is not spent.
                if (beat && req[sel_q] && (cnt_q < CNT_LAST)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (beat || !req[sel_q]) begin
                    ptr_d   = sel_q + SEL_W'(1);
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: per-cycle vector tables with a
// scoreboard queue, plus hand-written backpressure and async-reset sequences.
module tb_mux4_rr_arbiter;

    localparam int DATA_W = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] data_in;
    logic       out_ready;

    logic [3:0] ack_a,   ack_b;
    logic [1:0] sel_a,   sel_b;
    logic       valid_a, valid_b;
    logic [1:0] data_a,  data_b;
    logic [1:0] id_a,    id_b;

    int checks = 0;
    int errors = 0;

    mux4_rr_arbiter #(.DATA_W(DATA_W), .BURST(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack_a),
        .sel       (sel_a),
        .out_valid (valid_a),
        .out_ready (out_ready),
        .out_data  (data_a),
        .out_id    (id_a)
    );

    mux4_rr_arbiter #(.DATA_W(DATA_W), .BURST(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .ack       (ack_b),
        .sel       (sel_b),
        .out_valid (valid_b),
        .out_ready (out_ready),
        .out_data  (data_b),
        .out_id    (id_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] req;
        logic [7:0] din;
        logic       rdy;
        logic       valid;
        logic [1:0] sel;
        logic [1:0] data;
        logic [3:0] ack;
    } vec_t;

    typedef struct {
        bit         b1;
        logic       valid;
        logic [1:0] sel;
        logic [1:0] data;
        logic [3:0] ack;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    // Words: w3=01 w2=11 w1=10 w0=01
    localparam logic [7:0] D = 8'b01_11_10_01;

    function automatic vec_t mk(input logic [3:0] r, input logic [7:0] d, input logic rdy,
                                input logic val, input logic [1:0] s, input logic [1:0] dat,
                                input logic [3:0] a);
        vec_t x;
        x.req = r; x.din = d; x.rdy = rdy;
        x.valid = val; x.sel = s; x.data = dat; x.ack = a;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One vector = one clock cycle: drive just after the rising edge,
    // compare on the falling edge.
    task automatic apply(input vec_t x, input bit b1, input string name, input int i);
        exp_t e;
        @(posedge clk);
        #1;
        req       = x.req;
        data_in   = x.din;
        out_ready = x.rdy;
        e.b1 = b1; e.valid = x.valid; e.sel = x.sel; e.data = x.data; e.ack = x.ack;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            check($sformatf("%s[%0d].scoreboard_empty", name, i), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s[%0d].valid", name, i), e.b1 ? valid_b : valid_a, e.valid);
            check($sformatf("%s[%0d].sel",   name, i), e.b1 ? sel_b   : sel_a,   e.sel);
            check($sformatf("%s[%0d].id",    name, i), e.b1 ? id_b    : id_a,    e.sel);
            check($sformatf("%s[%0d].data",  name, i), e.b1 ? data_b  : data_a,  e.data);
            check($sformatf("%s[%0d].ack",   name, i), e.b1 ? ack_b   : ack_a,   e.ack);
        end
    endtask

    task automatic run_table(input string name, input bit b1);
        foreach (tbl[i]) apply(tbl[i], b1, name, i);
        tbl.delete();
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        req       = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({name, ".rst_valid"}, valid_a, 1'b0);
        check({name, ".rst_sel"},   sel_a,   2'd0);
        check({name, ".rst_id"},    id_a,    2'd0);
        check({name, ".rst_data"},  data_a,  2'd0);
        check({name, ".rst_ack"},   ack_a,   4'd0);
        check({name, ".rst_valid1"}, valid_b, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        data_in   = D;
        out_ready = 1'b0;

        // Single requester, ptr advance to 3, then wrap back to 0.
        do_reset("t1");
        tbl.push_back(mk(4'b0100, D, 1, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0000, D, 1, 1, 2'd2, 2'b11, 4'b0100));
        tbl.push_back(mk(4'b0000, D, 1, 0, 2'd2, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b1111, D, 1, 0, 2'd2, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0111, D, 1, 1, 2'd3, 2'b01, 4'b1000));
        tbl.push_back(mk(4'b0000, D, 1, 0, 2'd3, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0011, D, 1, 0, 2'd3, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0010, D, 1, 1, 2'd0, 2'b01, 4'b0001));
        tbl.push_back(mk(4'b0000, D, 1, 0, 2'd0, 2'b00, 4'b0000));
        run_table("single", 1'b0);

        // All four requesting with BURST=1: 0,1,2,3,0 with a bubble between.
        do_reset("t2");
        tbl.push_back(mk(4'b1111, D, 1, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b1111, D, 1, 1, 2'd0, 2'b01, 4'b0001));
        tbl.push_back(mk(4'b1111, D, 1, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b1111, D, 1, 1, 2'd1, 2'b10, 4'b0010));
        tbl.push_back(mk(4'b1111, D, 1, 0, 2'd1, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b1111, D, 1, 1, 2'd2, 2'b11, 4'b0100));
        tbl.push_back(mk(4'b1111, D, 1, 0, 2'd2, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b1111, D, 1, 1, 2'd3, 2'b01, 4'b1000));
        tbl.push_back(mk(4'b1111, D, 1, 0, 2'd3, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b1111, D, 1, 1, 2'd0, 2'b01, 4'b0001));
        run_table("rr_burst1", 1'b1);

        // BURST=2: two beats from 1, then rotation to pending 0, then 1 again.
        do_reset("t3");
        tbl.push_back(mk(4'b0010, D, 1, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0010, D, 1, 1, 2'd1, 2'b10, 4'b0010));
        tbl.push_back(mk(4'b0010, D, 1, 1, 2'd1, 2'b10, 4'b0010));
        tbl.push_back(mk(4'b0011, D, 1, 0, 2'd1, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0011, D, 1, 1, 2'd0, 2'b01, 4'b0001));
        tbl.push_back(mk(4'b0010, D, 1, 1, 2'd0, 2'b01, 4'b0001));
        tbl.push_back(mk(4'b0010, D, 1, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0000, D, 1, 1, 2'd1, 2'b10, 4'b0010));
        tbl.push_back(mk(4'b0000, D, 1, 0, 2'd1, 2'b00, 4'b0000));
        run_table("burst", 1'b0);

        // Backpressure on 3 for five cycles with out_data following data_in.
        do_reset("t4");
        tbl.push_back(mk(4'b1000, D, 0, 0, 2'd0, 2'b00, 4'b0000));
        for (int k = 0; k < 5; k++) begin
            logic [1:0] w3;
            w3 = (k % 2 == 0) ? 2'b10 : 2'b01;
            tbl.push_back(mk(4'b1000, {w3, 6'b11_10_01}, 0, 1, 2'd3, w3, 4'b0000));
        end
        tbl.push_back(mk(4'b0000, {2'b10, 6'b11_10_01}, 1, 1, 2'd3, 2'b10, 4'b1000));
        tbl.push_back(mk(4'b0000, D, 1, 0, 2'd3, 2'b00, 4'b0000));
        run_table("backpressure", 1'b0);

        // Withdraw from 0 without a beat; ptr=1 so 1 wins over re-raised 0.
        do_reset("t5");
        tbl.push_back(mk(4'b0011, D, 0, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0011, D, 0, 1, 2'd0, 2'b01, 4'b0000));
        tbl.push_back(mk(4'b0010, D, 0, 1, 2'd0, 2'b01, 4'b0000));
        tbl.push_back(mk(4'b0011, D, 0, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0011, D, 1, 1, 2'd1, 2'b10, 4'b0010));
        tbl.push_back(mk(4'b0001, D, 1, 1, 2'd1, 2'b10, 4'b0010));
        tbl.push_back(mk(4'b0000, D, 0, 0, 2'd1, 2'b00, 4'b0000));
        run_table("withdraw", 1'b0);

        // Async reset between edges during a grant to 2.
        do_reset("t6");
        tbl.push_back(mk(4'b0100, D, 0, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0100, D, 0, 1, 2'd2, 2'b11, 4'b0000));
        run_table("pre_reset", 1'b0);
        out_ready = 1'b1;
        #2;
        check("mid_grant.ack_before_reset", ack_a, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("async_rst.valid", valid_a, 1'b0);
        check("async_rst.ack",   ack_a,   4'b0000);
        check("async_rst.data",  data_a,  2'b00);
        check("async_rst.sel",   sel_a,   2'd0);
        check("async_rst.id",    id_a,    2'd0);
        req       = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tbl.push_back(mk(4'b1000, D, 1, 0, 2'd0, 2'b00, 4'b0000));
        tbl.push_back(mk(4'b0000, D, 1, 1, 2'd3, 2'b01, 4'b1000));
        tbl.push_back(mk(4'b0000, D, 1, 0, 2'd3, 2'b00, 4'b0000));
        run_table("post_reset", 1'b0);

        if (sb.size() != 0) check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
